// File: rtl/elevator_call_panel.sv
// elevator_call_panel: latches call buttons, serialises press pulses, clears on arrival, re-sends periodically; CALL_PANEL_LED_EN adds o_led
module elevator_call_panel #(
    parameter int NUM_FLOORS     = 8,
    parameter int ISSUE_GAP      = 2,
    parameter int DWELL_CYCLES   = 4,
    parameter int REFRESH_CYCLES = 64
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic [NUM_FLOORS-1:0] i_buttons,
    input  logic [2:0]            i_floor,
    output logic                  o_button_pressed,
    output logic [2:0]            o_button_value,
    output logic [NUM_FLOORS-1:0] o_pending,
    output logic                  o_arrived,
    output logic [2:0]            o_arrived_floor
`ifdef CALL_PANEL_LED_EN
    ,
    output logic [NUM_FLOORS-1:0] o_led
`endif
);
    localparam int PW = $clog2(NUM_FLOORS);
    localparam int RW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
    typedef enum logic [1:0] {IDLE, ISSUE, GAP} state_t;
    state_t state, state_n;
    logic [NUM_FLOORS-1:0] prev_buttons, sent, floor_hot, set_mask, clr_mask, eligible;
    logic [2:0] prev_floor, rr_ptr, pick;
    logic [7:0] dwell_cnt;
    logic [3:0] gap_cnt;
    logic [RW-1:0] refresh_cnt;
    logic stable, fire, refresh_fire, found;
    assign floor_hot = NUM_FLOORS'(1) << i_floor;
    assign stable = i_floor == prev_floor;
    assign fire = stable && dwell_cnt == 8'(DWELL_CYCLES - 1) && |(o_pending & floor_hot);
    assign set_mask = i_buttons & ~prev_buttons & ~((stable && dwell_cnt == 8'(DWELL_CYCLES)) ? floor_hot : '0);
    assign clr_mask = fire ? floor_hot : '0;
    assign refresh_fire = REFRESH_CYCLES > 0 && |o_pending && refresh_cnt == RW'(REFRESH_CYCLES - 1);
    assign eligible = o_pending & ~sent;
    assign o_button_pressed = state == ISSUE;
    always_comb begin
        pick = rr_ptr;
        found = 1'b0;
        // descending scan so the nearest candidate at/after rr_ptr wins
        for (int i = NUM_FLOORS - 1; i >= 0; i--) begin
            if (eligible[PW'((32'(rr_ptr) + 32'(i)) % NUM_FLOORS)]) begin
                pick = 3'((32'(rr_ptr) + 32'(i)) % NUM_FLOORS);
                found = 1'b1;
            end
        end
        state_n = state == IDLE  ? (found ? ISSUE : IDLE)
                : state == ISSUE ? (ISSUE_GAP == 0 ? IDLE : GAP)
                : (gap_cnt == 4'(ISSUE_GAP - 1) ? IDLE : GAP);
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state           <= IDLE;
            prev_buttons    <= '0;
            prev_floor      <= '0;
            dwell_cnt       <= '0;
            o_pending       <= '0;
            sent            <= '0;
            refresh_cnt     <= '0;
            gap_cnt         <= '0;
            rr_ptr          <= '0;
            o_button_value  <= '0;
            o_arrived       <= 1'b0;
            o_arrived_floor <= '0;
        end else begin
            state        <= state_n;
            prev_buttons <= i_buttons;
            prev_floor   <= i_floor;
            dwell_cnt    <= !stable ? '0 : dwell_cnt == 8'(DWELL_CYCLES) ? dwell_cnt : dwell_cnt + 8'd1;
            o_pending    <= (o_pending | set_mask) & ~clr_mask;
            // arrival clear beats both the refresh wipe and the issue mark
            sent         <= ((refresh_fire ? '0 : sent) | (o_button_pressed ? NUM_FLOORS'(1) << o_button_value : '0)) & ~clr_mask;
            refresh_cnt  <= (!(|o_pending) || refresh_fire) ? '0 : refresh_cnt + 1'b1;
            gap_cnt      <= state == GAP ? gap_cnt + 4'd1 : '0;
            if (state == IDLE && found) o_button_value <= pick;
            if (o_button_pressed) rr_ptr <= 3'((32'(o_button_value) + 32'd1) % NUM_FLOORS);
            o_arrived    <= fire;
            if (fire) o_arrived_floor <= i_floor;
        end
    end
`ifdef CALL_PANEL_LED_EN
    assign o_led = o_pending | set_mask;
`else
    // without lamps, fresh edges are only visible through o_pending a cycle later
`endif
endmodule
